// File: rtl/tsp_axis_burst_master.sv
// Burst reader for the TS packing FIFO: drains BURST_LEN words per bulk and emits
// each burst as one AXI4-Stream packet through a 2-entry credit-managed skid buffer.
module tsp_axis_burst_master #(
   parameter int C_M_AXIS_TDATA_WIDTH = 32,
   parameter int BURST_LEN            = 16
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                enable,
   input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     rdata,
   output logic                                r_enable,
   input  logic                                r_ready,
   output logic                                m_axis_tvalid,
   output logic [C_M_AXIS_TDATA_WIDTH-1:0]     m_axis_tdata,
   output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   m_axis_tstrb,
   output logic                                m_axis_tlast,
   input  logic                                m_axis_tready,
   output logic                                busy,
   output logic [31:0]                         burst_count
);

   localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN + 1) : 1;
   localparam logic [CNT_W-1:0] LEN       = CNT_W'(BURST_LEN);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t                            state, state_nxt;
   logic [CNT_W-1:0]                  rd_cnt;
   logic [CNT_W-1:0]                  wr_cnt;
   logic [1:0]                        occ;
   logic                              inflight;
   logic [C_M_AXIS_TDATA_WIDTH-1:0]   entry0, entry1;
   logic                              push, pop, credit_ok, tlast_hs, start;

   assign push          = inflight;
   assign pop           = m_axis_tvalid & m_axis_tready;
   assign m_axis_tvalid = (occ != 2'd0);
   assign m_axis_tdata  = entry0;
   assign m_axis_tstrb  = '1;
   assign m_axis_tlast  = m_axis_tvalid && (wr_cnt == LAST_BEAT);
   assign tlast_hs      = pop & m_axis_tlast;
   assign busy          = (state != IDLE);
   assign start         = (state == IDLE) && (state_nxt == READ);

   // A read may issue only if the word it returns is guaranteed a free skid slot.
   assign credit_ok = (({1'b0, occ} + {2'b00, inflight}) - {2'b00, pop}) < 3'd2;

   always_comb begin
      state_nxt = state;
      r_enable  = 1'b0;
      case (state)
         IDLE: begin
            if (enable && r_ready) state_nxt = READ;
         end
         READ: begin
            r_enable = credit_ok;
            if (credit_ok && (rd_cnt == CNT_W'(1))) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (tlast_hs) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rd_cnt      <= '0;
         wr_cnt      <= '0;
         inflight    <= 1'b0;
         burst_count <= '0;
      end else begin
         state    <= state_nxt;
         inflight <= r_enable;
         if (start)
            rd_cnt <= LEN;
         else if (r_enable)
            rd_cnt <= rd_cnt - CNT_W'(1);
         if (start)
            wr_cnt <= '0;
         else if (pop)
            wr_cnt <= (wr_cnt == LAST_BEAT) ? '0 : wr_cnt + CNT_W'(1);
         if (tlast_hs)
            burst_count <= burst_count + 32'd1;
      end
   end

   // Skid buffer: entry0 is always the head; a simultaneous push and pop keeps occ.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ    <= 2'd0;
         entry0 <= '0;
         entry1 <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (occ == 2'd0) entry0 <= rdata;
               else             entry1 <= rdata;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               entry0 <= entry1;
               occ    <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd1) begin
                  entry0 <= rdata;
               end else begin
                  entry0 <= entry1;
                  entry1 <= rdata;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_tsp_axis_burst_master.sv
// Bench for tsp_axis_burst_master: BURST_LEN=16 instance with a FIFO model and scoreboard,
// plus a BURST_LEN=1 instance for single-beat packets.
`timescale 1ns/1ps
module tb_tsp_axis_burst_master;
   localparam int W  = 32;
   localparam int BL = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          enable, r_ready, r_enable, tvalid, tlast, tready, busy;
   logic [W-1:0]  rdata = '0;
   logic [W-1:0]  tdata;
   logic [W/8-1:0] tstrb;
   logic [31:0]   burst_count;

   logic          b_enable, b_r_ready, b_r_enable, b_tvalid, b_tlast, b_tready, b_busy;
   logic [W-1:0]  b_rdata = '0;
   logic [W-1:0]  b_tdata;
   logic [W/8-1:0] b_tstrb;
   logic [31:0]   b_burst_count;

   tsp_axis_burst_master #(.C_M_AXIS_TDATA_WIDTH(W), .BURST_LEN(BL)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .rdata(rdata), .r_enable(r_enable),
      .r_ready(r_ready), .m_axis_tvalid(tvalid), .m_axis_tdata(tdata), .m_axis_tstrb(tstrb),
      .m_axis_tlast(tlast), .m_axis_tready(tready), .busy(busy), .burst_count(burst_count));

   tsp_axis_burst_master #(.C_M_AXIS_TDATA_WIDTH(W), .BURST_LEN(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .enable(b_enable), .rdata(b_rdata), .r_enable(b_r_enable),
      .r_ready(b_r_ready), .m_axis_tvalid(b_tvalid), .m_axis_tdata(b_tdata), .m_axis_tstrb(b_tstrb),
      .m_axis_tlast(b_tlast), .m_axis_tready(b_tready), .busy(b_busy), .burst_count(b_burst_count));

   // FIFO models: each read returns the next word of an incrementing sequence one cycle later.
   logic [W-1:0] fifo_ptr = 32'h00;
   logic [W-1:0] b_ptr    = 32'hA0;
   always @(posedge clk) if (r_enable)   begin rdata   <= fifo_ptr; fifo_ptr <= fifo_ptr + 1; end
   always @(posedge clk) if (b_r_enable) begin b_rdata <= b_ptr;    b_ptr    <= b_ptr + 1;    end

   typedef struct {
      int          duty;
      int          drop_beat;
      bit          check_first;
      logic [31:0] first_word;
      logic [31:0] exp_count;
   } burst_vec_t;

   burst_vec_t   vecs[4];
   int           n_cmp = 0, n_fail = 0;
   logic [W-1:0] exp_q[$];
   int           reads = 0, beats = 0, beat_idx = 0, burst_reads = 0, burst_beats = 0;
   int           duty = 100;
   logic         stall_prev = 1'b0, last_hs = 1'b0;
   logic [W-1:0] prev_data = '0, first_data = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock: drive tready after the edge, then sample and score at the falling edge.
   task automatic step();
      logic [W-1:0] e;
      @(posedge clk);
      #1;
      tready = ($urandom_range(99) < duty);
      @(negedge clk);
      last_hs = 1'b0;
      if (rst_n) begin
         check("outstanding_le2", 32'((reads - beats) <= 2), 32'd1);
         if (r_enable) begin
            check("ren_only_when_busy", 32'(busy), 32'd1);
            exp_q.push_back(fifo_ptr);
            reads++;
            burst_reads++;
         end
         if (stall_prev) begin
            check("stall_tvalid", 32'(tvalid), 32'd1);
            check("stall_tdata", tdata, prev_data);
         end
         if (!tvalid) check("tlast_without_tvalid", 32'(tlast), 32'd0);
         if (tvalid && tready) begin
            check("beat_has_read", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("tdata_order", tdata, e);
            end
            check("tlast_pos", 32'(tlast), 32'(beat_idx == BL - 1));
            if (beat_idx == 0) first_data = tdata;
            last_hs  = tlast;
            beat_idx = (beat_idx == BL - 1) ? 0 : beat_idx + 1;
            beats++;
            burst_beats++;
         end
         stall_prev = tvalid && !tready;
         prev_data  = tdata;
      end
   endtask

   task automatic run_burst(input burst_vec_t v);
      int  n;
      int  r0;
      bit  done;
      duty        = v.duty;
      burst_reads = 0;
      burst_beats = 0;
      enable      = 1'b1;
      r_ready     = 1'b1;
      step();
      n = 0;
      while (!busy && n < 50) begin step(); n++; end
      check("burst_start", 32'(busy), 32'd1);
      r_ready = 1'b0;
      done = 1'b0;
      n = 0;
      while (!done && n < 2000) begin
         if (v.drop_beat >= 0 && burst_beats == v.drop_beat) begin
            enable  = 1'b0;
            r_ready = 1'b1;
         end
         step();
         if (last_hs) done = 1'b1;
         n++;
      end
      check("burst_done", 32'(done), 32'd1);
      if (v.check_first) check("first_word", first_data, v.first_word);
      check("burst_reads", 32'(burst_reads), 32'(BL));
      check("burst_beats", 32'(burst_beats), 32'(BL));
      step();
      check("burst_count", burst_count, v.exp_count);
      check("busy_after_burst", 32'(busy), 32'd0);
      if (v.drop_beat >= 0) begin
         r0 = reads;
         repeat (10) step();
         check("no_burst_while_disabled", 32'(reads - r0), 32'd0);
         check("idle_while_disabled", 32'(busy), 32'd0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int viol, n, hs, b_reads;
      bit idle_seen;
      vecs[0] = '{100, -1, 1'b1, 32'h00, 32'd1};
      vecs[1] = '{ 30, -1, 1'b1, 32'h10, 32'd2};
      vecs[2] = '{100,  5, 1'b1, 32'h20, 32'd3};
      vecs[3] = '{ 60,  5, 1'b1, 32'h30, 32'd4};

      rst_n = 1'b0; enable = 1'b0; r_ready = 1'b0; tready = 1'b0;
      b_enable = 1'b0; b_r_ready = 1'b0; b_tready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_r_enable", 32'(r_enable), 32'd0);
      check("rst_tvalid", 32'(tvalid), 32'd0);
      check("rst_tlast", 32'(tlast), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_tdata", tdata, 32'd0);
      check("rst_burst_count", burst_count, 32'd0);
      check("tstrb_all_ones", 32'(tstrb), 32'hF);
      rst_n = 1'b1;

      // No bulk available: nothing may move.
      enable = 1'b1; r_ready = 1'b0; duty = 100; viol = 0;
      repeat (100) begin
         step();
         if (r_enable || tvalid || busy) viol++;
      end
      check("idle_no_activity", 32'(viol), 32'd0);
      check("idle_burst_count", burst_count, 32'd0);

      for (int i = 0; i < 4; i++) run_burst(vecs[i]);

      // Asynchronous reset in the middle of a burst.
      duty = 100; enable = 1'b1; r_ready = 1'b1; burst_beats = 0;
      step();
      r_ready = 1'b0;
      n = 0;
      while (burst_beats < 8 && n < 200) begin step(); n++; end
      check("reached_beat8", 32'(burst_beats), 32'd8);
      #2 rst_n = 1'b0;
      #1;
      check("arst_r_enable", 32'(r_enable), 32'd0);
      check("arst_tvalid", 32'(tvalid), 32'd0);
      check("arst_tlast", 32'(tlast), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_tdata", tdata, 32'd0);
      check("arst_burst_count", burst_count, 32'd0);
      exp_q.delete();
      reads = 0; beats = 0; beat_idx = 0; stall_prev = 1'b0;
      step(); step();
      rst_n = 1'b1;
      run_burst('{100, -1, 1'b0, 32'h0, 32'd1});

      // BURST_LEN=1: four single-beat packets, each with tlast, separated by an idle cycle.
      enable = 1'b0; r_ready = 1'b0;
      b_enable = 1'b1; b_r_ready = 1'b1; b_tready = 1'b1;
      hs = 0; b_reads = 0; idle_seen = 1'b1; n = 0;
      while (hs < 4 && n < 100) begin
         @(posedge clk); #1; @(negedge clk);
         if (b_r_enable) begin
            b_reads++;
            check("b_idle_gap", 32'(idle_seen), 32'd1);
            idle_seen = 1'b0;
         end
         if (!b_busy) idle_seen = 1'b1;
         if (b_tvalid && b_tready) begin
            check("b_tlast", 32'(b_tlast), 32'd1);
            check("b_tdata", b_tdata, 32'hA0 + 32'(hs));
            hs++;
         end
         n++;
      end
      b_enable = 1'b0;
      repeat (6) begin
         @(posedge clk); #1; @(negedge clk);
         if (b_r_enable) b_reads++;
      end
      check("b_beats", 32'(hs), 32'd4);
      check("b_reads", 32'(b_reads), 32'd4);
      check("b_burst_count", b_burst_count, 32'd4);
      check("b_busy_after", 32'(b_busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
